mem_byte_resp: RTL and testbench
================================

MEM_BYTE_RESP -- requirements
Module: mem_byte_resp

Responder end of the CPU data-access path. It accepts 20-bit physical-address requests (byte or word, read or write) from the core and executes them on a byte-wide external memory port. Word accesses are split into two little-endian byte cycles.

Interface
REQ-001 Parameter: ACK_TIMEOUT, default 255, maximum cycles to wait for mem_ack per byte cycle (range 1..255).
REQ-002 clk  input  1  single rising-edge clock.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  1  request present; sampled only while req_ready=1.
REQ-005 req_ready  output  1  block idle and able to accept a request.
REQ-006 req_addr  input  20  physical byte address (seg*16+off, computed upstream).
REQ-007 req_we  input  1  1=write, 0=read.
REQ-008 req_word  input  1  1=16-bit access, 0=8-bit access.
REQ-009 req_wdata  input  16  write data; byte access uses [7:0].
REQ-010 req_done  output  1  one-cycle pulse at transaction completion.
REQ-011 req_rdata  output  16  read data; valid while req_done=1.
REQ-012 req_err  output  1  valid with req_done; 1 = a byte cycle timed out.
REQ-013 mem_cs  output  1  byte-cycle strobe.
REQ-014 mem_we  output  1  byte-cycle write enable.
REQ-015 mem_addr  output  20  byte address.
REQ-016 mem_wdata  output  8  byte write data.
REQ-017 mem_rdata  input  8  byte read data; sampled on the edge where mem_ack=1.
REQ-018 mem_ack  input  1  byte-cycle completion from memory.

Function
REQ-019 The FSM SHALL have four states: IDLE, LO, HI and DONE. req_ready=1 only in IDLE.
REQ-020 In IDLE with req_valid=1 at a clock edge, the block SHALL register addr, we, word and wdata, and enter LO.
REQ-021 In LO, the block SHALL hold mem_cs=1, mem_addr=addr, mem_we=we and mem_wdata=wdata[7:0] until mem_ack is sampled high.
REQ-022 On ack in LO, the block SHALL capture mem_rdata into rdata[7:0], then enter HI if word=1, else DONE.
REQ-023 In HI, the block SHALL hold mem_cs=1, mem_addr=(addr+1) mod 2^20 (0xFFFFF wraps to 0x00000), mem_we=we and mem_wdata=wdata[15:8]. On ack it SHALL capture rdata[15:8] and enter DONE.
REQ-024 The block SHALL drop mem_cs for at least the cycle following each ack; LO->HI therefore has one idle bus cycle.
REQ-025 In DONE, the block SHALL assert req_done=1 for exactly one cycle, then return to IDLE.
REQ-026 On byte reads, req_rdata[15:8] SHALL be 0x00. On writes, req_rdata SHALL be 0x0000.
REQ-027 Latency from the request-sampling edge to req_done: byte access = 2 + (ack wait) cycles minimum 2; word access = 4 cycles minimum.
REQ-028 An 8-bit wait counter SHALL clear on entry to LO and HI, and increment each cycle mem_cs=1 and mem_ack=0.
REQ-029 When the wait counter reaches ACK_TIMEOUT without ack, the block SHALL abort the transaction: drop mem_cs, skip any remaining byte, enter DONE with req_err=1 and req_rdata=0xFFFF.
REQ-030 If ack and the timeout coincide in the same cycle, ack SHALL win (normal completion).
REQ-031 mem_ack while mem_cs=0 SHALL be ignored.
REQ-032 req_valid while req_ready=0 SHALL be ignored and not queued.
REQ-033 req_err SHALL be 0 whenever req_done=0.

Reset
REQ-034 When rst asserts, including mid-transaction, the block SHALL immediately (asynchronously) enter IDLE and drop the in-flight transfer with no req_done.
REQ-035 During rst, outputs SHALL be req_ready=0, req_done=0, req_err=0, req_rdata=0, mem_cs=0, mem_we=0, mem_addr=0 and mem_wdata=0; the counter and captured registers SHALL be 0.
REQ-036 On the first clock edge after rst deasserts, req_ready SHALL be 1.

Verification
REQ-037 Byte read: addr=0x12345, memory returns 0xA5 with immediate ack -> one mem_cs cycle at 0x12345; req_done two cycles after acceptance; rdata=0x00A5; err=0.
REQ-038 Word write: addr=0x00100, wdata=0xBEEF -> byte cycles 0x00100/0xEF then 0x00101/0xBE, with an idle cycle between; req_done; rdata=0x0000.
REQ-039 Word read across wrap: addr=0xFFFFF, memory 0xFFFFF=0x34 and 0x00000=0x12 -> second mem_addr=0x00000; rdata=0x1234.
REQ-040 Timeout: ACK_TIMEOUT=4, mem_ack never asserted on a word read -> mem_cs drops after 4 wait cycles; no HI cycle; req_done with err=1 and rdata=0xFFFF. A repeat run with ack on the 4th wait cycle completes normally.
REQ-041 Reset mid-word: rst pulses during the HI cycle -> mem_cs=0 immediately; no req_done; a following byte request completes normally.
REQ-042 Back-pressure: req_valid held high through a word transaction -> exactly one request accepted per IDLE visit; no request accepted in LO, HI or DONE.

Source files
------------

// File: rtl/mem_byte_resp.sv
// Core data-access responder: runs byte or word requests on a byte-wide memory
// port, splitting words into two little-endian byte cycles with an ack timeout.
module mem_byte_resp #(
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [19:0] req_addr,
   input  logic        req_we,
   input  logic        req_word,
   input  logic [15:0] req_wdata,
   output logic        req_done,
   output logic [15:0] req_rdata,
   output logic        req_err,
   output logic        mem_cs,
   output logic        mem_we,
   output logic [19:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_ack
);

   typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

   // Abort fires on the edge closing the ACK_TIMEOUT-th unanswered strobe cycle.
   localparam logic [7:0] WAIT_LAST = 8'(ACK_TIMEOUT - 1);

   state_t      state, state_nxt;
   logic [19:0] addr_r;
   logic        we_r;
   logic        word_r;
   logic [15:0] wdata_r;
   logic [15:0] rdata_r;
   logic [7:0]  wait_cnt;
   logic        gap_r;
   logic        err_r;
   logic        accept;
   logic        ack_hit;
   logic        timeout;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      req_done  = 1'b0;
      req_err   = 1'b0;
      req_rdata = 16'h0000;
      mem_cs    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = 20'h00000;
      mem_wdata = 8'h00;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            req_ready = ~rst;
            accept    = req_valid & ~rst;
            if (accept) state_nxt = LO;
         end
         LO: begin
            mem_cs    = 1'b1;
            mem_we    = we_r;
            mem_addr  = addr_r;
            mem_wdata = wdata_r[7:0];
         end
         HI: begin
            // First HI cycle is the mandatory idle bus cycle after the low-byte ack.
            if (!gap_r) begin
               mem_cs    = 1'b1;
               mem_we    = we_r;
               mem_addr  = addr_r + 20'd1;
               mem_wdata = wdata_r[15:8];
            end
         end
         DONE: begin
            req_done  = 1'b1;
            req_err   = err_r;
            req_rdata = err_r ? 16'hFFFF : (we_r ? 16'h0000 : rdata_r);
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      ack_hit = mem_cs & mem_ack;
      timeout = mem_cs & ~mem_ack & (wait_cnt == WAIT_LAST);
      if (ack_hit)      state_nxt = (state == LO && word_r) ? HI : DONE;
      else if (timeout) state_nxt = DONE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_r   <= 20'h00000;
         we_r     <= 1'b0;
         word_r   <= 1'b0;
         wdata_r  <= 16'h0000;
         rdata_r  <= 16'h0000;
         wait_cnt <= 8'h00;
         gap_r    <= 1'b0;
         err_r    <= 1'b0;
      end else begin
         gap_r <= 1'b0;
         if (accept) begin
            addr_r   <= req_addr;
            we_r     <= req_we;
            word_r   <= req_word;
            wdata_r  <= req_wdata;
            rdata_r  <= 16'h0000;
            err_r    <= 1'b0;
            wait_cnt <= 8'h00;
         end else if (ack_hit) begin
            if (state == LO) rdata_r[7:0]  <= mem_rdata;
            else             rdata_r[15:8] <= mem_rdata;
            wait_cnt <= 8'h00;
            gap_r    <= (state == LO);
         end else if (timeout) begin
            err_r    <= 1'b1;
            wait_cnt <= 8'h00;
         end else if (mem_cs) begin
            wait_cnt <= wait_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_mem_byte_resp.sv
// Directed bench for mem_byte_resp: a transaction-level model expands each request
// into the expected per-cycle bus trace, checked every cycle against the DUT.
module tb_mem_byte_resp;

   localparam int T = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [19:0] req_addr;
   logic        req_we;
   logic        req_word;
   logic [15:0] req_wdata;
   logic        req_done;
   logic [15:0] req_rdata;
   logic        req_err;
   logic        mem_cs;
   logic        mem_we;
   logic [19:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        mem_ack;

   mem_byte_resp #(.ACK_TIMEOUT(T)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_we(req_we), .req_word(req_word), .req_wdata(req_wdata),
      .req_done(req_done), .req_rdata(req_rdata), .req_err(req_err),
      .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rdy, cs, we, done, err, full;
      logic [19:0] addr;
      logic [7:0]  wd;
      logic [15:0] rd;
   } exp_t;

   exp_t        exp_q[$];
   int          n_vec = 0;
   int          n_bad = 0;
   int          cs_seen = 0;
   int          done_cnt = 0;
   logic [15:0] last_rd = 16'h0000;
   logic        last_err = 1'b0;

   // Memory responder: ack after ack_delay strobe cycles; noise_en drives ack while idle.
   int          ack_delay = 0;
   int          resp_cnt = 0;
   logic        ack_en = 1'b1;
   logic        noise_en = 1'b0;
   logic [19:0] wr_addr [16];
   logic [7:0]  wr_data [16];
   int          wr_n = 0;

   function automatic logic [7:0] mem_rd(input logic [19:0] a);
      logic [7:0] v;
      case (a)
         20'h12345: v = 8'hA5;
         20'hFFFFF: v = 8'h34;
         20'h00000: v = 8'h12;
         default:   v = a[7:0] ^ 8'h5A;
      endcase
      for (int i = 0; i < wr_n; i++) if (wr_addr[i] == a) v = wr_data[i];
      return v;
   endfunction

   assign mem_ack   = mem_cs ? (ack_en && resp_cnt == ack_delay) : noise_en;
   assign mem_rdata = mem_rd(mem_addr);

   always @(posedge clk) begin
      if (mem_cs && !mem_ack) resp_cnt <= resp_cnt + 1;
      else                    resp_cnt <= 0;
      if (mem_cs && mem_ack && mem_we && wr_n < 16) begin
         wr_addr[wr_n] <= mem_addr;
         wr_data[wr_n] <= mem_wdata;
         wr_n          <= wr_n + 1;
      end
   end

   always @(negedge clk) begin : cmp
      exp_t e;
      logic bad;
      if (mem_cs) cs_seen++;
      if (req_done) begin
         done_cnt++;
         last_rd  = req_rdata;
         last_err = req_err;
      end
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_vec++;
         bad = (req_ready !== e.rdy) || (mem_cs !== e.cs) || (req_done !== e.done) || (req_err !== e.err);
         if (e.cs || e.full) bad = bad || (mem_we !== e.we) || (mem_addr !== e.addr) || (mem_wdata !== e.wd);
         if (e.done || e.full) bad = bad || (req_rdata !== e.rd);
         if (bad) begin
            n_bad++;
            $display("FAIL cycle@%0t: got rdy=%b cs=%b we=%b addr=%h wd=%h done=%b err=%b rd=%h, expected rdy=%b cs=%b we=%b addr=%h wd=%h done=%b err=%b rd=%h",
                     $time, req_ready, mem_cs, mem_we, mem_addr, mem_wdata, req_done, req_err, req_rdata,
                     e.rdy, e.cs, e.we, e.addr, e.wd, e.done, e.err, e.rd);
         end
      end
   end

   function automatic exp_t mk(input logic rdy, input logic cs, input logic we, input logic [19:0] addr,
                               input logic [7:0] wd, input logic done, input logic err,
                               input logic [15:0] rd, input logic full);
      exp_t e;
      e.rdy = rdy; e.cs = cs; e.we = we; e.addr = addr; e.wd = wd;
      e.done = done; e.err = err; e.rd = rd; e.full = full;
      return e;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", nm, act, req);
      end
   endtask

   // One byte cycle: strobe held until the ack, or for T cycles when it never comes.
   task automatic push_byte(input logic [19:0] a, input logic we, input logic [7:0] wd, output logic ok);
      int n;
      ok = ack_en && (ack_delay < T);
      n  = ok ? ack_delay + 1 : T;
      for (int i = 0; i < n; i++) exp_q.push_back(mk(1'b0, 1'b1, we, a, wd, 1'b0, 1'b0, 16'h0, 1'b0));
   endtask

   task automatic push_txn(input logic [19:0] a, input logic we, input logic word, input logic [15:0] wd,
                           input logic lead, output logic [15:0] rd);
      logic ok;
      if (lead) exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 20'h0, 8'h0, 1'b0, 1'b0, 16'h0, 1'b0));
      push_byte(a, we, wd[7:0], ok);
      rd = {8'h00, mem_rd(a)};
      if (ok && word) begin
         exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 20'h0, 8'h0, 1'b0, 1'b0, 16'h0, 1'b0));
         push_byte(a + 20'd1, we, wd[15:8], ok);
         rd[15:8] = mem_rd(a + 20'd1);
      end
      if (!ok)     rd = 16'hFFFF;
      else if (we) rd = 16'h0000;
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 20'h0, 8'h0, 1'b1, ~ok, rd, 1'b0));
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 20'h0, 8'h0, 1'b0, 1'b0, 16'h0, 1'b0));
   endtask

   task automatic drain(input string nm);
      int g = 0;
      while (exp_q.size() > 0 && g < 200) begin
         @(posedge clk); #1;
         g++;
      end
      if (exp_q.size() > 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL %s drain: %0d trace entries left, required 0", nm, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic run(input string nm, input logic [19:0] a, input logic we, input logic word,
                      input logic [15:0] wd, input int d, input logic aen,
                      input logic [15:0] lit_rd, input int lit_cs, input logic lit_err);
      logic [15:0] mrd;
      ack_delay = d;
      ack_en    = aen;
      push_txn(a, we, word, wd, 1'b1, mrd);
      chk({nm, " model rdata"}, 32'(mrd), 32'(lit_rd));
      cs_seen   = 0;
      done_cnt  = 0;
      req_addr  = a;
      req_we    = we;
      req_word  = word;
      req_wdata = wd;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      drain(nm);
      chk({nm, " rdata"}, 32'(last_rd), 32'(lit_rd));
      chk({nm, " err"}, 32'(last_err), 32'(lit_err));
      chk({nm, " strobe cycles"}, 32'(cs_seen), 32'(lit_cs));
      chk({nm, " done pulses"}, 32'(done_cnt), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   initial begin
      logic        ok;
      logic [15:0] rd1, rd2;
      rst = 1'b1; req_valid = 1'b0; req_addr = 20'h0; req_we = 1'b0; req_word = 1'b0; req_wdata = 16'h0;
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 20'h0, 8'h0, 1'b0, 1'b0, 16'h0, 1'b1));
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 20'h0, 8'h0, 1'b0, 1'b0, 16'h0, 1'b1));
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      @(posedge clk); #1;

      run("byte read 12345", 20'h12345, 1'b0, 1'b0, 16'h0000, 0, 1'b1, 16'h00A5, 1, 1'b0);
      noise_en = 1'b1;
      run("word write 00100", 20'h00100, 1'b1, 1'b1, 16'hBEEF, 0, 1'b1, 16'h0000, 2, 1'b0);
      chk("mem 00100", 32'(mem_rd(20'h00100)), 32'hEF);
      chk("mem 00101", 32'(mem_rd(20'h00101)), 32'hBE);
      run("word read wrap", 20'hFFFFF, 1'b0, 1'b1, 16'h0000, 1, 1'b1, 16'h1234, 4, 1'b0);
      run("byte write 00200", 20'h00200, 1'b1, 1'b0, 16'h77AA, 2, 1'b1, 16'h0000, 3, 1'b0);
      chk("mem 00200", 32'(mem_rd(20'h00200)), 32'hAA);
      chk("mem 00201 untouched", 32'(mem_rd(20'h00201)), 32'h5B);
      run("byte read 00100", 20'h00100, 1'b0, 1'b0, 16'h0000, 0, 1'b1, 16'h00EF, 1, 1'b0);
      run("word read timeout", 20'h00300, 1'b0, 1'b1, 16'h0000, 0, 1'b0, 16'hFFFF, 4, 1'b1);
      run("word read ack at limit", 20'h00100, 1'b0, 1'b1, 16'h0000, 3, 1'b1, 16'hBEEF, 8, 1'b0);

      // Reset pulse landing in the high-byte strobe cycle of a word read.
      ack_delay = 0;
      ack_en    = 1'b1;
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 20'h0, 8'h0, 1'b0, 1'b0, 16'h0, 1'b0));
      push_byte(20'h00400, 1'b0, 8'h00, ok);
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 20'h0, 8'h0, 1'b0, 1'b0, 16'h0, 1'b0));
      done_cnt  = 0;
      req_addr  = 20'h00400; req_we = 1'b0; req_word = 1'b1; req_wdata = 16'h0; req_valid = 1'b1;
      @(posedge clk); #1 req_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("hi strobe before reset", 32'(mem_cs), 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("strobe during reset", 32'(mem_cs), 32'd0);
      chk("ready during reset", 32'(req_ready), 32'd0);
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 20'h0, 8'h0, 1'b0, 1'b0, 16'h0, 1'b1));
      @(negedge clk); #1 rst = 1'b0;
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 20'h0, 8'h0, 1'b0, 1'b0, 16'h0, 1'b0));
      drain("reset recovery");
      chk("no done after reset", 32'(done_cnt), 32'd0);
      run("byte read after reset", 20'h12345, 1'b0, 1'b0, 16'h0000, 0, 1'b1, 16'h00A5, 1, 1'b0);

      // Valid held high: word then byte accepted, one per idle visit.
      ack_delay = 0;
      ack_en    = 1'b1;
      push_txn(20'h00500, 1'b0, 1'b1, 16'h0000, 1'b1, rd1);
      push_txn(20'h12345, 1'b0, 1'b0, 16'h0000, 1'b0, rd2);
      chk("backpressure model rdata 1", 32'(rd1), 32'h5B5A);
      chk("backpressure model rdata 2", 32'(rd2), 32'h00A5);
      cs_seen   = 0;
      done_cnt  = 0;
      req_addr  = 20'h00500; req_we = 1'b0; req_word = 1'b1; req_valid = 1'b1;
      @(posedge clk); #1;
      req_addr  = 20'h12345; req_word = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      drain("backpressure");
      chk("backpressure done pulses", 32'(done_cnt), 32'd2);
      chk("backpressure strobe cycles", 32'(cs_seen), 32'd3);
      chk("backpressure last rdata", 32'(last_rd), 32'h00A5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
